lsu_mem_ctrl: RTL and testbench

- Load/store initiator for the 1 KiB data memory: the requester side of the memory's addr/din/dout/WriteEn port.
- Accepts byte, halfword and word loads/stores from the pipeline MEM stage and drives word-aligned memory accesses.
- Sub-word stores are done as read-modify-write.
- Returns sign- or zero-extended load data; flags misaligned accesses.

---
 rtl/lsu_mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a word-organised data memory; sub-word stores use read-modify-write.
// Optional LSU_BOUNDS_CHECK_EN: nonzero req_addr bits above ADDR_WIDTH-1 become an access error.
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    input  logic [31:0]           mem_dout,
    output logic                  mem_we
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRmwRd,
        StWrite,
        StResp
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [31:0]           data_q, data_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  req_err;
    logic [4:0]            lane_sh;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           ld_ext;
    logic [31:0]           merge_mask;
    logic [31:0]           merged;

    always_comb begin
        unique case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
`ifdef LSU_BOUNDS_CHECK_EN
        if (|req_addr[31:ADDR_WIDTH]) begin
            req_err = 1'b1;
        end
`endif
    end

`ifndef LSU_BOUNDS_CHECK_EN
    // Upper address bits wrap silently in this build.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];
`endif

    // Little-endian lane extraction; halfword lanes are 0 or 2 since addr[0] is known clear.
    assign lane_sh = {addr_q[1:0], 3'b000};
    assign ld_byte = mem_dout[lane_sh +: 8];
    assign ld_half = mem_dout[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        case (size_q)
            2'b00:   ld_ext = signed_q ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
            2'b01:   ld_ext = signed_q ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
            default: ld_ext = mem_dout;
        endcase
    end

    assign merge_mask = ((size_q == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff) << lane_sh;
    assign merged     = (mem_dout & ~merge_mask) | ((data_q << lane_sh) & merge_mask);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d   = req_addr[ADDR_WIDTH-1:0];
                    size_d   = req_size;
                    signed_d = req_signed;
                    data_d   = req_wdata;
                    if (req_err) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else if (!req_write) begin
                        state_d = StLoad;
                    end else if (req_size == 2'b10) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StLoad: begin
                rdata_d = ld_ext;
                err_d   = 1'b0;
                state_d = StResp;
            end
            StRmwRd: begin
                data_d  = merged;
                state_d = StWrite;
            end
            StWrite: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            data_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Outputs are forced low while reset is held, not just after the reset edge.
    always_comb begin
        req_ready  = rst_n && (state_q == StIdle);
        resp_valid = rst_n && (state_q == StResp);
        resp_rdata = rst_n ? rdata_q : '0;
        resp_err   = rst_n && err_q;
        mem_we     = rst_n && (state_q == StWrite);
        mem_din    = (rst_n && (state_q == StWrite)) ? data_q : '0;
        mem_addr   = '0;
        if (rst_n && (state_q == StLoad || state_q == StRmwRd || state_q == StWrite)) begin
            mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl with a 256-word memory model.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_we;

    logic [31:0] mem [0:255];
    int          we_cnt = 0;
    int          align_bad = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_WIDTH(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_we     (mem_we)
    );

    assign mem_dout = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_din;
            we_cnt <= we_cnt + 1;
        end
        if (mem_addr[1:0] != 2'b00) align_bad <= align_bad + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request from idle and check data, error, latency, write count and pulse width.
    task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_lat, input int exp_we);
        int lat;
        int we0;
        logic [31:0] rd;
        logic er;
        @(negedge clk);
        check_eq({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_size = sz;
        req_signed = sg;
        req_addr = a;
        req_wdata = wd;
        we0 = we_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99;
        rd = '0;
        er = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) check_eq({tag, "_busy"}, {31'b0, req_ready}, 32'd0);
            if (resp_valid) begin
                lat = i;
                rd = resp_rdata;
                er = resp_err;
                break;
            end
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_rdata"}, rd, exp_rd);
        check_eq({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
        @(negedge clk);
        check_eq({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
        check_eq({tag, "_hold"}, resp_rdata, exp_rd);
        check_eq({tag, "_we"}, we_cnt - we0, exp_we);
    endtask

    initial begin
        int we0;
        int vcnt;
        logic [31:0] oob_rd;
        logic        oob_err;
        int          oob_lat;

        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'b0, req_ready}, 32'd0);
        check_eq("rst_valid", {31'b0, resp_valid}, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_err", {31'b0, resp_err}, 32'd0);
        check_eq("rst_we", {31'b0, mem_we}, 32'd0);
        check_eq("rst_maddr", {22'b0, mem_addr}, 32'd0);
        check_eq("rst_mdin", mem_din, 32'd0);
        rst_n = 1'b1;

        run("sw0",   1'b1, 2'b10, 1'b0, 32'h000, 32'h1234_5678, 32'h0, 1'b0, 2, 1);
        run("lw0",   1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 32'h1234_5678, 1'b0, 2, 0);
        run("lbu1",  1'b0, 2'b00, 1'b0, 32'h001, 32'h0, 32'h0000_0056, 1'b0, 2, 0);
        run("lh2",   1'b0, 2'b01, 1'b1, 32'h002, 32'h0, 32'h0000_1234, 1'b0, 2, 0);
        run("sb2",   1'b1, 2'b00, 1'b0, 32'h002, 32'hFFFF_FFAB, 32'h0, 1'b0, 3, 1);
        run("lw0b",  1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 32'h12AB_5678, 1'b0, 2, 0);
        run("lb2s",  1'b0, 2'b00, 1'b1, 32'h002, 32'h0, 32'hFFFF_FFAB, 1'b0, 2, 0);
        run("lb2u",  1'b0, 2'b00, 1'b0, 32'h002, 32'h0, 32'h0000_00AB, 1'b0, 2, 0);

        run("elw1",  1'b0, 2'b10, 1'b0, 32'h001, 32'h0, 32'h0, 1'b1, 1, 0);
        run("esh3",  1'b1, 2'b01, 1'b0, 32'h003, 32'hBEEF, 32'h0, 1'b1, 1, 0);
        run("esz3",  1'b0, 2'b11, 1'b0, 32'h000, 32'h0, 32'h0, 1'b1, 1, 0);
        check_eq("err_mem", mem[0], 32'h12AB_5678);

        // Byte store interrupted by reset while in the read phase of RMW.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size = 2'b00;
        req_signed = 1'b0;
        req_addr = 32'h000;
        req_wdata = 32'h0000_00FF;
        we0 = we_cnt;
        vcnt = 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (resp_valid) vcnt++;
            check_eq("mrst_ready", {31'b0, req_ready}, 32'd0);
            check_eq("mrst_we", {31'b0, mem_we}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) vcnt++;
        end
        check_eq("mrst_ready_up", {31'b0, req_ready}, 32'd1);
        check_eq("mrst_novalid", vcnt, 32'd0);
        check_eq("mrst_nowrite", we_cnt - we0, 32'd0);
        run("lw0c",  1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 32'h12AB_5678, 1'b0, 2, 0);

`ifdef LSU_BOUNDS_CHECK_EN
        oob_rd = 32'h0;
        oob_err = 1'b1;
        oob_lat = 1;
`else
        oob_rd = 32'h12AB_5678;
        oob_err = 1'b0;
        oob_lat = 2;
`endif
        run("lw400", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, oob_rd, oob_err, oob_lat, 0);

        run("sh0",   1'b1, 2'b01, 1'b0, 32'h000, 32'h1111_8001, 32'h0, 1'b0, 3, 1);
        run("lw0d",  1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 32'h12AB_8001, 1'b0, 2, 0);
        run("lh0s",  1'b0, 2'b01, 1'b1, 32'h000, 32'h0, 32'hFFFF_8001, 1'b0, 2, 0);
        run("lhu0",  1'b0, 2'b01, 1'b0, 32'h000, 32'h0, 32'h0000_8001, 1'b0, 2, 0);
        run("sb3",   1'b1, 2'b00, 1'b0, 32'h003, 32'h0000_0077, 32'h0, 1'b0, 3, 1);
        run("lw0e",  1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 32'h77AB_8001, 1'b0, 2, 0);
        check_eq("align", align_bad, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
